// File: rtl/store_buffer_pkg.sv
// Shared sizing constants and index helpers for the store buffer.
// Entry numbers are raw ring indices; age is always measured as an offset from head.
package store_buffer_pkg;

    localparam int SB_ENTRY   = 8;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;

    localparam int SB_NUM_W = $clog2(SB_ENTRY);
    localparam int SB_CNT_W = SB_NUM_W + 1;

    typedef logic [SB_NUM_W-1:0] sb_num_t;
    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

    localparam sb_cnt_t SB_FULL_CNT = sb_cnt_t'(SB_ENTRY);

    // Age of an entry relative to a base pointer; wraps naturally at SB_ENTRY.
    function automatic sb_num_t sb_offset(input sb_num_t idx, input sb_num_t base);
        return idx - base;
    endfunction

    function automatic sb_cnt_t sb_widen(input sb_num_t v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/sb_ptr_ctrl.sv
// Head/commit/tail pointers and occupancy counters of the store buffer ring.
// Decides which of allocate, commit and drain fire each cycle and applies flush rollback.
module sb_ptr_ctrl
    import store_buffer_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                alloc_v_i,
    input  logic                commit_v_i,
    input  logic                cmt_wb_i,
    input  logic                flush_i,
    input  logic                mem_ready_i,
    output logic [SB_NUM_W-1:0] head_o,
    output logic [SB_NUM_W-1:0] cmt_o,
    output logic [SB_NUM_W-1:0] tail_o,
    output logic [SB_CNT_W-1:0] alloc_cnt_o,
    output logic [SB_CNT_W-1:0] cmt_cnt_o,
    output logic [SB_CNT_W-1:0] keep_cnt_o,
    output logic                alloc_fire_o,
    output logic                drain_fire_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                mem_v_o
);

    sb_num_t head_q, head_d;
    sb_num_t cmt_q, cmt_d;
    sb_num_t tail_q, tail_d;
    sb_cnt_t alloc_cnt_q, alloc_cnt_d;
    sb_cnt_t cmt_cnt_q, cmt_cnt_d;

    logic    full;
    logic    empty;
    logic    mem_v;
    logic    alloc_fire;
    logic    commit_fire;
    logic    drain_fire;
    sb_cnt_t keep_cnt;

    always_comb begin
        full        = (alloc_cnt_q == SB_FULL_CNT);
        empty       = (alloc_cnt_q == '0);
        mem_v       = (cmt_cnt_q != '0);

        // Full is judged on registered state only, so a same-cycle drain never frees a slot.
        alloc_fire  = alloc_v_i & ~full & ~flush_i;
        commit_fire = commit_v_i & cmt_wb_i & (cmt_cnt_q < alloc_cnt_q);
        drain_fire  = mem_v & mem_ready_i;

        keep_cnt    = cmt_cnt_q + sb_cnt_t'(commit_fire);

        head_d      = head_q + sb_num_t'(drain_fire);
        cmt_d       = cmt_q + sb_num_t'(commit_fire);
        cmt_cnt_d   = keep_cnt - sb_cnt_t'(drain_fire);

        if (flush_i) begin
            tail_d      = cmt_d;
            alloc_cnt_d = cmt_cnt_d;
        end else begin
            tail_d      = tail_q + sb_num_t'(alloc_fire);
            alloc_cnt_d = alloc_cnt_q + sb_cnt_t'(alloc_fire) - sb_cnt_t'(drain_fire);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            head_q      <= '0;
            cmt_q       <= '0;
            tail_q      <= '0;
            alloc_cnt_q <= '0;
            cmt_cnt_q   <= '0;
        end else begin
            head_q      <= head_d;
            cmt_q       <= cmt_d;
            tail_q      <= tail_d;
            alloc_cnt_q <= alloc_cnt_d;
            cmt_cnt_q   <= cmt_cnt_d;
        end
    end

    // The ROB may only retire a store that has been written back and not yet committed.
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        commit_v_i |-> (cmt_wb_i && (cmt_cnt_q < alloc_cnt_q)));

    assign head_o       = head_q;
    assign cmt_o        = cmt_q;
    assign tail_o       = tail_q;
    assign alloc_cnt_o  = alloc_cnt_q;
    assign cmt_cnt_o    = cmt_cnt_q;
    assign keep_cnt_o   = keep_cnt;
    assign alloc_fire_o = alloc_fire;
    assign drain_fire_o = drain_fire;
    assign full_o       = full;
    assign empty_o      = empty;
    assign mem_v_o      = mem_v;

endmodule

// File: rtl/store_buffer.sv
// Circular buffer of in-flight stores: allocate at dispatch, capture at writeback,
// commit in order, drain committed stores to memory (valid/ready), flush squashes the rest.
module store_buffer
    import store_buffer_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  alloc_v_i,
    output logic [SB_NUM_W-1:0]   alloc_sb_num_o,
    output logic                  full_o,
    input  logic                  wb_v_i,
    input  logic [SB_NUM_W-1:0]   wb_sb_num_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  commit_v_i,
    input  logic                  flush_i,
    output logic [SB_ENTRY-1:0]   sb_wb_vector_o,
    output logic [SB_NUM_W-1:0]   sb_commit_pt_o,
    output logic                  mem_v_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic                  mem_ready_i,
    output logic                  empty_o
);

    sb_num_t head;
    sb_num_t cmt;
    sb_num_t tail;
    sb_cnt_t alloc_cnt;
    sb_cnt_t cmt_cnt;
    sb_cnt_t keep_cnt;
    logic    alloc_fire;
    logic    drain_fire;

    logic [SB_ENTRY-1:0]   wb_q, wb_d;
    logic [ADDR_WIDTH-1:0] addr_q [SB_ENTRY];
    logic [ADDR_WIDTH-1:0] addr_d [SB_ENTRY];
    logic [DATA_WIDTH-1:0] data_q [SB_ENTRY];
    logic [DATA_WIDTH-1:0] data_d [SB_ENTRY];

    sb_num_t wb_off;
    logic    wb_accept;

    sb_ptr_ctrl u_ptr (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .alloc_v_i    (alloc_v_i),
        .commit_v_i   (commit_v_i),
        .cmt_wb_i     (wb_q[cmt]),
        .flush_i      (flush_i),
        .mem_ready_i  (mem_ready_i),
        .head_o       (head),
        .cmt_o        (cmt),
        .tail_o       (tail),
        .alloc_cnt_o  (alloc_cnt),
        .cmt_cnt_o    (cmt_cnt),
        .keep_cnt_o   (keep_cnt),
        .alloc_fire_o (alloc_fire),
        .drain_fire_o (drain_fire),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .mem_v_o      (mem_v_o)
    );

    // Only allocated, not-yet-committed entries accept writeback; committed data is final,
    // which also keeps the head store stable while memory stalls.
    always_comb begin
        wb_off    = sb_offset(wb_sb_num_i, head);
        wb_accept = wb_v_i & ~flush_i
                  & (sb_widen(wb_off) < alloc_cnt)
                  & (sb_widen(wb_off) >= cmt_cnt);
    end

    always_comb begin
        wb_d   = wb_q;
        addr_d = addr_q;
        data_d = data_q;

        if (flush_i) begin
            for (int i = 0; i < SB_ENTRY; i++) begin
                if (sb_widen(sb_offset(sb_num_t'(i), head)) >= keep_cnt) begin
                    wb_d[i] = 1'b0;
                end
            end
        end

        if (wb_accept) begin
            wb_d[wb_sb_num_i]   = 1'b1;
            addr_d[wb_sb_num_i] = wb_addr_i;
            data_d[wb_sb_num_i] = wb_data_i;
        end

        if (alloc_fire) begin
            wb_d[tail] = 1'b0;
        end

        if (drain_fire) begin
            wb_d[head] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    // Payload storage carries no reset; validity lives entirely in wb_q and the counters.
    always_ff @(posedge clk_i) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (wb_v_i && alloc_fire) |-> (wb_sb_num_i != tail));

    assign alloc_sb_num_o = tail;
    assign sb_commit_pt_o = head;
    assign sb_wb_vector_o = wb_q;
    assign mem_addr_o     = addr_q[head];
    assign mem_data_o     = data_q[head];

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: linear steps, drained stores checked against an expected queue.
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  reset_n_i = 1'b0;
    logic                  alloc_v_i = 1'b0;
    logic [SB_NUM_W-1:0]   alloc_sb_num_o;
    logic                  full_o;
    logic                  wb_v_i = 1'b0;
    logic [SB_NUM_W-1:0]   wb_sb_num_i = '0;
    logic [ADDR_WIDTH-1:0] wb_addr_i = '0;
    logic [DATA_WIDTH-1:0] wb_data_i = '0;
    logic                  commit_v_i = 1'b0;
    logic                  flush_i = 1'b0;
    logic [SB_ENTRY-1:0]   sb_wb_vector_o;
    logic [SB_NUM_W-1:0]   sb_commit_pt_o;
    logic                  mem_v_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_data_o;
    logic                  mem_ready_i = 1'b0;
    logic                  empty_o;

    store_buffer dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .alloc_v_i      (alloc_v_i),
        .alloc_sb_num_o (alloc_sb_num_o),
        .full_o         (full_o),
        .wb_v_i         (wb_v_i),
        .wb_sb_num_i    (wb_sb_num_i),
        .wb_addr_i      (wb_addr_i),
        .wb_data_i      (wb_data_i),
        .commit_v_i     (commit_v_i),
        .flush_i        (flush_i),
        .sb_wb_vector_o (sb_wb_vector_o),
        .sb_commit_pt_o (sb_commit_pt_o),
        .mem_v_o        (mem_v_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_ready_i    (mem_ready_i),
        .empty_o        (empty_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] exp_q[$];
    logic [ADDR_WIDTH-1:0] m_addr [SB_ENTRY];
    logic [DATA_WIDTH-1:0] m_data [SB_ENTRY];
    int next_cmt = 0;
    int passed = 0;
    int failed = 0;
    int total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A drain happens at the next rising edge whenever valid and ready are both high here.
    always @(negedge clk_i) begin
        if (reset_n_i && mem_v_o && mem_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("drain_unexpected", {31'd0, mem_v_o}, 32'd0);
            end else begin
                logic [ADDR_WIDTH+DATA_WIDTH-1:0] e;
                e = exp_q.pop_front();
                chk("drain_addr", {16'd0, mem_addr_o}, {16'd0, e[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH]});
                chk("drain_data", {16'd0, mem_data_o}, {16'd0, e[DATA_WIDTH-1:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        alloc_v_i   = 1'b0;
        wb_v_i      = 1'b0;
        commit_v_i  = 1'b0;
        flush_i     = 1'b0;
        mem_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset_n_i = 1'b0;
        step();
        step();
        reset_n_i = 1'b1;
        exp_q.delete();
        next_cmt = 0;
    endtask

    task automatic alloc_n(input int n);
        alloc_v_i = 1'b1;
        repeat (n) step();
        alloc_v_i = 1'b0;
    endtask

    task automatic wb(input int idx);
        wb_v_i      = 1'b1;
        wb_sb_num_i = SB_NUM_W'(idx);
        wb_addr_i   = 16'($urandom_range(0, 65535));
        wb_data_i   = 16'($urandom_range(0, 65535));
        m_addr[idx] = wb_addr_i;
        m_data[idx] = wb_data_i;
        step();
        wb_v_i = 1'b0;
    endtask

    task automatic push_commit();
        exp_q.push_back({m_addr[next_cmt], m_data[next_cmt]});
        next_cmt = (next_cmt + 1) % SB_ENTRY;
    endtask

    task automatic commit_n(input int n);
        commit_v_i = 1'b1;
        for (int k = 0; k < n; k++) begin
            push_commit();
            step();
        end
        commit_v_i = 1'b0;
    endtask

    task automatic drain_n(input int n);
        mem_ready_i = 1'b1;
        repeat (n) step();
        mem_ready_i = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_full"},  {31'd0, full_o}, 32'd0);
        chk({tag, "_empty"}, {31'd0, empty_o}, 32'd1);
        chk({tag, "_mem_v"}, {31'd0, mem_v_o}, 32'd0);
        chk({tag, "_wbvec"}, {24'd0, sb_wb_vector_o}, 32'd0);
        chk({tag, "_cpt"},   {29'd0, sb_commit_pt_o}, 32'd0);
        chk({tag, "_anum"},  {29'd0, alloc_sb_num_o}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset values, then fill the buffer.
        do_reset();
        chk_reset_outputs("rst");
        for (int i = 0; i < SB_ENTRY; i++) begin
            chk("fill_anum", {29'd0, alloc_sb_num_o}, i);
            alloc_n(1);
        end
        chk("fill_full", {31'd0, full_o}, 32'd1);
        chk("fill_anum_wrap", {29'd0, alloc_sb_num_o}, 32'd0);
        alloc_n(1);
        chk("ninth_full", {31'd0, full_o}, 32'd1);
        chk("ninth_anum", {29'd0, alloc_sb_num_o}, 32'd0);
        chk("ninth_empty", {31'd0, empty_o}, 32'd0);

        // Out-of-order writeback; writeback to an unallocated entry is dropped.
        do_reset();
        alloc_n(3);
        wb(2);
        chk("wb2_vec", {24'd0, sb_wb_vector_o}, 32'h04);
        wb(0);
        chk("wb0_vec", {24'd0, sb_wb_vector_o}, 32'h05);
        chk("wb_cpt", {29'd0, sb_commit_pt_o}, 32'd0);
        wb(5);
        chk("wb_unalloc_vec", {24'd0, sb_wb_vector_o}, 32'h05);
        chk("wb_no_commit_mem_v", {31'd0, mem_v_o}, 32'd0);

        // Commit then stall memory: head store must be held.
        do_reset();
        alloc_n(2);
        wb(0);
        wb(1);
        commit_n(2);
        for (int k = 0; k < 3; k++) begin
            chk("stall_mem_v", {31'd0, mem_v_o}, 32'd1);
            chk("stall_addr", {16'd0, mem_addr_o}, {16'd0, m_addr[0]});
            chk("stall_data", {16'd0, mem_data_o}, {16'd0, m_data[0]});
            step();
        end
        drain_n(2);
        chk("drain_cpt", {29'd0, sb_commit_pt_o}, 32'd2);
        chk("drain_empty", {31'd0, empty_o}, 32'd1);
        chk("drain_mem_v", {31'd0, mem_v_o}, 32'd0);
        chk("drain_wbvec", {24'd0, sb_wb_vector_o}, 32'd0);
        chk("drain_q", exp_q.size(), 32'd0);

        // Wrap-around.
        do_reset();
        alloc_n(6);
        for (int i = 0; i < 6; i++) wb(i);
        commit_n(6);
        drain_n(6);
        chk("wrap_empty", {31'd0, empty_o}, 32'd1);
        chk("wrap_cpt", {29'd0, sb_commit_pt_o}, 32'd6);
        for (int k = 0; k < 4; k++) begin
            logic [SB_NUM_W-1:0] e;
            e = SB_NUM_W'(6 + k);
            chk("wrap_anum", {29'd0, alloc_sb_num_o}, {29'd0, e});
            alloc_n(1);
        end
        chk("wrap_cpt2", {29'd0, sb_commit_pt_o}, 32'd6);
        chk("wrap_not_empty", {31'd0, empty_o}, 32'd0);
        chk("wrap_not_full", {31'd0, full_o}, 32'd0);
        alloc_n(4);
        chk("wrap_full", {31'd0, full_o}, 32'd1);
        chk("wrap_full_anum", {29'd0, alloc_sb_num_o}, 32'd6);
        wb(7);
        wb(0);
        chk("wrap_wbvec", {24'd0, sb_wb_vector_o}, 32'h81);
        chk("wrap_q", exp_q.size(), 32'd0);

        // Flush with same-cycle commit.
        do_reset();
        alloc_n(5);
        for (int i = 0; i < 5; i++) wb(i);
        commit_n(2);
        flush_i    = 1'b1;
        commit_v_i = 1'b1;
        push_commit();
        step();
        idle();
        chk("flush_anum", {29'd0, alloc_sb_num_o}, 32'd3);
        chk("flush_wbvec", {24'd0, sb_wb_vector_o}, 32'h07);
        chk("flush_mem_v", {31'd0, mem_v_o}, 32'd1);
        chk("flush_empty", {31'd0, empty_o}, 32'd0);
        wb(4);
        chk("flush_wb_squashed", {24'd0, sb_wb_vector_o}, 32'h07);
        drain_n(3);
        chk("flush_drain_empty", {31'd0, empty_o}, 32'd1);
        chk("flush_drain_cpt", {29'd0, sb_commit_pt_o}, 32'd3);
        chk("flush_drain_wbvec", {24'd0, sb_wb_vector_o}, 32'd0);
        chk("flush_q", exp_q.size(), 32'd0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_empty_anum", {29'd0, alloc_sb_num_o}, 32'd3);
        chk("flush_empty_empty", {31'd0, empty_o}, 32'd1);

        // Full buffer: alloc + commit + drain in one cycle, then reset mid-drain.
        do_reset();
        alloc_n(8);
        for (int i = 0; i < 8; i++) wb(i);
        commit_n(1);
        alloc_v_i   = 1'b1;
        commit_v_i  = 1'b1;
        mem_ready_i = 1'b1;
        push_commit();
        step();
        idle();
        chk("combo_full", {31'd0, full_o}, 32'd0);
        chk("combo_anum", {29'd0, alloc_sb_num_o}, 32'd0);
        chk("combo_cpt", {29'd0, sb_commit_pt_o}, 32'd1);
        chk("combo_mem_v", {31'd0, mem_v_o}, 32'd1);
        chk("combo_wbvec", {24'd0, sb_wb_vector_o}, 32'hFE);
        chk("combo_q", exp_q.size(), 32'd1);
        reset_n_i   = 1'b0;
        mem_ready_i = 1'b1;
        alloc_v_i   = 1'b1;
        step();
        idle();
        reset_n_i = 1'b1;
        exp_q.delete();
        chk_reset_outputs("midrst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Circular FIFO of in-flight stores.
- Allocates an entry per store at dispatch and captures address/data at execute writeback.
- Marks entries committed in order as the ROB retires them, then drains committed entries to the data-memory port over a valid/ready handshake.
- Produces the writeback vector and commit (head) pointer that the issue stage consumes for its older-store ordering check; also supports a flush that squashes uncommitted entries.

Parameters:
- SB_ENTRY, 8, number of entries; power of two, at least 2.
- ADDR_WIDTH, 16, store address width.
- DATA_WIDTH, 16, store data width.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous, active-low reset
- alloc_v_i  in  1  dispatch requests one entry
- alloc_sb_num_o  out  $clog2(SB_ENTRY)  entry granted (= tail)
- full_o  out  1  no free entry; alloc_v_i ignored while high
- wb_v_i  in  1  execute writeback valid
- wb_sb_num_i  in  $clog2(SB_ENTRY)  entry being written back
- wb_addr_i  in  ADDR_WIDTH  store address
- wb_data_i  in  DATA_WIDTH  store data
- commit_v_i  in  1  ROB retires the oldest uncommitted store
- flush_i  in  1  squash all uncommitted entries
- sb_wb_vector_o  out  SB_ENTRY  bit i set = entry i written back
- sb_commit_pt_o  out  $clog2(SB_ENTRY)  head: oldest undrained entry
- mem_v_o  out  1  committed store available to drain
- mem_addr_o  out  ADDR_WIDTH  head entry address
- mem_data_o  out  DATA_WIDTH  head entry data
- mem_ready_i  in  1  memory accepts the head store
- empty_o  out  1  no allocated entries

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (reset_n_i sampled on clk_i rising edge).
- State:
  - pointers head, cmt, tail, each $clog2(SB_ENTRY) bits, wrap mod SB_ENTRY;
  - counters alloc_cnt (head..tail) and cmt_cnt (head..cmt), each $clog2(SB_ENTRY)+1 bits;
  - per entry: wb bit, addr, data.
- Reset (reset_n_i=0 at edge):
  - head, cmt, tail, alloc_cnt, cmt_cnt = 0; all wb bits = 0; addr/data not reset.
  - Outputs after reset: full_o=0, empty_o=1, mem_v_o=0, sb_wb_vector_o=0, sb_commit_pt_o=0, alloc_sb_num_o=0.
  - Reset overrides all same-cycle inputs.
- Derived outputs (combinational from registers, no input bypass):
  - full_o = (alloc_cnt==SB_ENTRY); empty_o = (alloc_cnt==0); mem_v_o = (cmt_cnt!=0).
  - alloc_sb_num_o = tail; sb_commit_pt_o = head; mem_addr_o/mem_data_o = entry[head].
- Allocate: alloc_v_i & ~full_o & ~flush_i → entry[tail].wb cleared, tail+1, alloc_cnt+1. Bit visible cleared in sb_wb_vector_o at the next cycle.
- Writeback: wb_v_i & ~flush_i → entry[wb_sb_num_i] addr/data captured, wb bit set; visible next cycle.
  - A writeback to an unallocated entry, or to an uncommitted entry during flush, is ignored.
  - Writeback and allocate of the same index in one cycle cannot occur (entry must be allocated first); assert.
- Commit: commit_v_i → cmt+1, cmt_cnt+1.
  - Entry[cmt] must have wb=1 and cmt_cnt<alloc_cnt; assert, otherwise ignore.
  - Earliest mem_v_o for that entry: cycle after commit.
- Drain: mem_v_o & mem_ready_i → head+1, alloc_cnt−1, cmt_cnt−1, entry[head].wb cleared.
  - mem_addr_o/mem_data_o are held stable while mem_v_o=1 and mem_ready_i=0.
- Flush: flush_i → commit of the same cycle is applied first, then tail = post-commit cmt, alloc_cnt = post-commit cmt_cnt (minus drain if any), and wb bits of squashed entries are cleared.
  - Committed entries survive and keep draining.
- Simultaneous events:
  - Alloc and drain in the same cycle: both apply; alloc_cnt is unchanged.
  - When full, alloc is refused even if a drain occurs that cycle (no bypass).
  - Commit and drain in the same cycle: cmt_cnt is unchanged.
  - Flush while empty: no effect.
- Wrap-around: all pointers wrap at SB_ENTRY.
  - sb_commit_pt_o and entry numbers stay raw indices; consumers subtract the head modulo SB_ENTRY.

Decomposition:
- Shared package constants: SB_ENTRY, ADDR_WIDTH, DATA_WIDTH, and a sb_num_t typedef of $clog2(SB_ENTRY) bits.
- One natural sub-module: sb_ptr_ctrl (head/cmt/tail pointers, counters, full/empty/flush arithmetic). The entry array and wb vector stay in store_buffer.

Test Plan:
- Reset then 8 allocs → alloc_sb_num_o 0..7; full_o=1 after 8th; a 9th alloc_v_i leaves tail=0 and alloc_cnt=8.
- Alloc 3, writeback entries 2 then 0 → sb_wb_vector_o=0000_0100 then 0000_0101; sb_commit_pt_o=0.
- Alloc 2, wb both, commit both, mem_ready_i=0 for 3 cycles → mem_v_o=1 and address/data of entry 0 held; ready=1 two cycles → head=2, empty_o=1, wb bits 0,1 cleared.
- Wrap: drain 6 entries, alloc 4 → alloc_sb_num_o 6,7,0,1; sb_commit_pt_o=6; full/empty correct across the wrap.
- Alloc 5, commit 2, flush_i with commit_v_i the same cycle → tail=3, alloc_cnt=3, wb bits 3,4 cleared; entries 0–2 drain normally.
- Full buffer with alloc_v_i, commit, and mem_ready_i in one cycle → alloc refused; drain applies; full_o=0 next cycle; reset mid-drain → all outputs return to reset values next cycle.
